// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC vectoring datapath and its channel scheduler.
package cordic_pkg;

    localparam int DATA_W     = 16;
    localparam int ANGLE_W    = 18;
    localparam int CORDIC_LAT = 18;
    localparam int MAX_NCH    = 16;

    typedef logic [$clog2(MAX_NCH)-1:0] chan_tag_t;

    // Channel-tag width: at least one bit even for a two-channel build.
    function automatic int chan_w(input int nch);
        return (nch > 2) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/cordic_rr_scheduler_if.sv
// Per-channel sample handshake bundle between the IQ sources and the scheduler.
interface cordic_rr_scheduler_if #(parameter int NCH = 4);
    import cordic_pkg::*;

    logic [NCH-1:0]        s_valid;
    logic [NCH-1:0]        s_ready;
    logic [NCH*DATA_W-1:0] s_x_re;
    logic [NCH*DATA_W-1:0] s_x_im;

    modport master (output s_valid, output s_x_re, output s_x_im, input s_ready);
    modport slave  (input s_valid, input s_x_re, input s_x_im, output s_ready);

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin request search: first requester at or after ptr, wrapping modulo NCH.
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int CW  = 2
) (
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  ptr,
    output logic [NCH-1:0] grant,
    output logic [CW-1:0]  idx,
    output logic           any
);

    // Rotating priority search; the first hit freezes the result.
    always_comb begin : search
        int            cand;
        logic [CW-1:0] cidx;
        logic          hit;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            cand         = int'(ptr) + k;
            cand         = (cand >= NCH) ? (cand - NCH) : cand;
            cidx         = CW'(cand);
            hit          = !any && req[cidx];
            grant[cidx]  = grant[cidx] | hit;
            idx          = hit ? cidx : idx;
            any          = any | hit;
        end
    end

endmodule

// File: rtl/cordic_rr_scheduler.sv
// Shares one non-stallable CORDIC pipeline among NCH IQ channels: round-robin issue,
// a channel-tag pipe matching the CORDIC latency, and a downstream credit counter.
module cordic_rr_scheduler
    import cordic_pkg::*;
#(
    parameter  int NCH     = 4,
    parameter  int LAT     = CORDIC_LAT,
    parameter  int CREDITS = 8,
    localparam int CW      = chan_w(NCH),
    localparam int CRW     = $clog2(CREDITS + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    cordic_rr_scheduler_if.slave     s,
    output logic signed [DATA_W-1:0] c_x_re,
    output logic signed [DATA_W-1:0] c_x_im,
    output logic                     c_valid,
    output logic [CW-1:0]            c_chan,
    output logic                     m_valid,
    output logic [CW-1:0]            m_chan,
    input  logic                     credit_ret,
    output logic [CRW-1:0]           credits,
    output logic                     busy,
    output logic                     err_credit
);

    localparam logic [CRW-1:0] CRED_FULL = CRW'(CREDITS);

    logic [CW-1:0]            ptr_r;
    logic [NCH-1:0]           grant_s;
    logic [CW-1:0]            win_s;
    logic                     any_s;
    logic                     hs_s;
    logic [CW-1:0]            ptr_nxt_s;
    logic [CRW-1:0]           credits_nxt_s;
    logic signed [DATA_W-1:0] sel_re_s;
    logic signed [DATA_W-1:0] sel_im_s;
    logic [LAT-1:0]           pv_r;
    logic [CW-1:0]            pc_r [LAT];

    rr_arbiter #(.NCH(NCH), .CW(CW)) u_arb (
        .req   (s.s_valid),
        .ptr   (ptr_r),
        .grant (grant_s),
        .idx   (win_s),
        .any   (any_s)
    );

    // Grant qualification, ready fan-out and winner data select.
    always_comb begin
        hs_s     = enable && (credits != '0) && any_s;
        sel_re_s = s.s_x_re[int'(win_s)*DATA_W +: DATA_W];
        sel_im_s = s.s_x_im[int'(win_s)*DATA_W +: DATA_W];
        if (hs_s) begin
            s.s_ready = grant_s;
        end else begin
            s.s_ready = '0;
        end
        if (int'(win_s) == NCH - 1) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = win_s + CW'(1);
        end
    end

    // Next credit count; a simultaneous take and return cancel out.
    always_comb begin
        credits_nxt_s = credits;
        if (hs_s && !credit_ret) begin
            credits_nxt_s = credits - CRW'(1);
        end else if (!hs_s && credit_ret && (credits != CRED_FULL)) begin
            credits_nxt_s = credits + CRW'(1);
        end else begin
            credits_nxt_s = credits;
        end
    end

    // Issue registers and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_valid <= 1'b0;
            c_chan  <= '0;
            c_x_re  <= '0;
            c_x_im  <= '0;
            ptr_r   <= '0;
        end else begin
            c_valid <= hs_s;
            c_chan  <= hs_s ? win_s : '0;
            c_x_re  <= hs_s ? sel_re_s : '0;
            c_x_im  <= hs_s ? sel_im_s : '0;
            ptr_r   <= hs_s ? ptr_nxt_s : ptr_r;
        end
    end

    // Credit counter and sticky over-return flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credits    <= CRED_FULL;
            err_credit <= 1'b0;
        end else begin
            credits <= credits_nxt_s;
            if (credit_ret && (credits == CRED_FULL)) begin
                err_credit <= 1'b1;
            end else begin
                err_credit <= err_credit;
            end
        end
    end

    // Tag pipe: shifts every cycle in lockstep with the CORDIC stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pv_r <= '0;
            for (int i = 0; i < LAT; i++) begin
                pc_r[i] <= '0;
            end
        end else begin
            pv_r[0] <= c_valid;
            pc_r[0] <= c_chan;
            for (int i = 1; i < LAT; i++) begin
                pv_r[i] <= pv_r[i-1];
                pc_r[i] <= pc_r[i-1];
            end
        end
    end

    assign m_valid = pv_r[LAT-1];
    assign m_chan  = pc_r[LAT-1];
    assign busy    = (|pv_r) || (credits != CRED_FULL);

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Scenario bench for cordic_rr_scheduler with a cycle-accurate scoreboard on the issue and result ports.
module tb_cordic_rr_scheduler;
    import cordic_pkg::*;

    localparam int NCH     = 4;
    localparam int LAT     = 18;
    localparam int CREDITS = 8;
    localparam int CW      = chan_w(NCH);
    localparam int CRW     = $clog2(CREDITS + 1);

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic                     enable = 1'b0;
    logic                     credit_ret = 1'b0;
    logic signed [DATA_W-1:0] c_x_re;
    logic signed [DATA_W-1:0] c_x_im;
    logic                     c_valid;
    logic [CW-1:0]            c_chan;
    logic                     m_valid;
    logic [CW-1:0]            m_chan;
    logic [CRW-1:0]           credits;
    logic                     busy;
    logic                     err_credit;

    cordic_rr_scheduler_if #(.NCH(NCH)) bus ();

    cordic_rr_scheduler #(.NCH(NCH), .LAT(LAT), .CREDITS(CREDITS)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .s          (bus.slave),
        .c_x_re     (c_x_re),
        .c_x_im     (c_x_im),
        .c_valid    (c_valid),
        .c_chan     (c_chan),
        .m_valid    (m_valid),
        .m_chan     (m_chan),
        .credit_ret (credit_ret),
        .credits    (credits),
        .busy       (busy),
        .err_credit (err_credit)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          chan;
        logic [15:0] re;
        logic [15:0] im;
    } item_t;

    int             total = 0;
    int             bad = 0;
    int             cyc = 0;
    item_t          c_q[$];
    item_t          m_q[$];
    item_t          cit;
    int             mptr = 0;
    int             mcred = CREDITS;
    logic           merr = 1'b0;
    int             win;
    int             ci;
    logic [NCH-1:0] exp_ready;
    logic           exp_busy;

    // Reference model: predicts ready, credits, err and busy, schedules issue and result slots.
    always @(negedge clk) begin
        if (!reset) begin
            c_q.delete();
            m_q.delete();
            mptr  = 0;
            mcred = CREDITS;
            merr  = 1'b0;
            total++;
            if (c_valid !== 1'b0 || m_valid !== 1'b0 || credits !== CRW'(CREDITS) || busy !== 1'b0 ||
                err_credit !== 1'b0 || c_x_re !== 16'sd0 || c_x_im !== 16'sd0 || c_chan !== '0) begin
                bad++;
                $display("FAIL reset_hold: c_valid=%0b m_valid=%0b credits=%0d busy=%0b err=%0b want 0/0/%0d/0/0",
                         c_valid, m_valid, credits, busy, err_credit, CREDITS);
            end
        end else begin
            exp_busy = (mcred != CREDITS) || (m_q.size() > 0 && (m_q[0].due - LAT) < cyc);
            total++;
            if (busy !== exp_busy) begin
                bad++;
                $display("FAIL busy cyc=%0d: got %0b want %0b", cyc, busy, exp_busy);
            end
            total++;
            if (c_q.size() > 0 && c_q[0].due == cyc) begin
                cit = c_q.pop_front();
                if (c_valid !== 1'b1 || int'(c_chan) !== cit.chan || c_x_re !== cit.re || c_x_im !== cit.im) begin
                    bad++;
                    $display("FAIL issue cyc=%0d: got v=%0b ch=%0d re=%0d im=%0d want v=1 ch=%0d re=%0d im=%0d",
                             cyc, c_valid, c_chan, c_x_re, c_x_im, cit.chan, $signed(cit.re), $signed(cit.im));
                end
            end else if (c_valid !== 1'b0 || c_x_re !== 16'sd0 || c_x_im !== 16'sd0 || c_chan !== '0) begin
                bad++;
                $display("FAIL issue_idle cyc=%0d: got v=%0b ch=%0d re=%0d im=%0d want all 0",
                         cyc, c_valid, c_chan, c_x_re, c_x_im);
            end
            total++;
            if (m_q.size() > 0 && m_q[0].due == cyc) begin
                cit = m_q.pop_front();
                if (m_valid !== 1'b1 || int'(m_chan) !== cit.chan) begin
                    bad++;
                    $display("FAIL result cyc=%0d: got v=%0b ch=%0d want v=1 ch=%0d", cyc, m_valid, m_chan, cit.chan);
                end
            end else if (m_valid !== 1'b0) begin
                bad++;
                $display("FAIL result_idle cyc=%0d: got m_valid=%0b want 0", cyc, m_valid);
            end
            total++;
            if (credits !== CRW'(mcred) || err_credit !== merr) begin
                bad++;
                $display("FAIL credit_state cyc=%0d: got credits=%0d err=%0b want %0d/%0b",
                         cyc, credits, err_credit, mcred, merr);
            end
            win = -1;
            exp_ready = '0;
            if (enable === 1'b1 && mcred != 0) begin
                for (int k = 0; k < NCH; k++) begin
                    ci = (mptr + k) % NCH;
                    if (win < 0 && bus.s_valid[ci] === 1'b1) begin
                        win = ci;
                    end
                end
            end
            if (win >= 0) begin
                exp_ready[win] = 1'b1;
            end
            total++;
            if (bus.s_ready !== exp_ready) begin
                bad++;
                $display("FAIL s_ready cyc=%0d: got %b want %b", cyc, bus.s_ready, exp_ready);
            end
            if (credit_ret === 1'b1 && mcred == CREDITS) begin
                merr = 1'b1;
            end
            if (win >= 0) begin
                cit.due  = cyc + 1;
                cit.chan = win;
                cit.re   = bus.s_x_re[win*16 +: 16];
                cit.im   = bus.s_x_im[win*16 +: 16];
                c_q.push_back(cit);
                cit.due  = cyc + 1 + LAT;
                m_q.push_back(cit);
                mptr     = (win + 1) % NCH;
            end
            if (win >= 0 && credit_ret !== 1'b1) begin
                mcred--;
            end else if (win < 0 && credit_ret === 1'b1 && mcred != CREDITS) begin
                mcred++;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NCH; i++) begin
            bus.s_x_re[i*16 +: 16] = 16'($urandom);
            bus.s_x_im[i*16 +: 16] = 16'($urandom);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        enable = 1'b0;
        credit_ret = 1'b0;
        bus.s_valid = '0;
        bus.s_x_re = '0;
        bus.s_x_im = '0;
        repeat (3) tick();
        total++;
        if (credits !== CRW'(CREDITS) || busy !== 1'b0 || err_credit !== 1'b0 || c_valid !== 1'b0 || m_valid !== 1'b0) begin
            bad++;
            $display("FAIL test_reset: credits=%0d busy=%0b err=%0b c_valid=%0b m_valid=%0b want %0d/0/0/0/0",
                     credits, busy, err_credit, c_valid, m_valid, CREDITS);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int n;
        enable = 1'b1;
        bus.s_x_re[2*16 +: 16] = 16'sd1000;
        bus.s_x_im[2*16 +: 16] = -16'sd500;
        bus.s_valid = 4'b0100;
        #1;
        total++;
        if (bus.s_ready !== 4'b0100) begin
            bad++;
            $display("FAIL single_ready: got %b want 0100", bus.s_ready);
        end
        tick();
        bus.s_valid = '0;
        total++;
        if (c_valid !== 1'b1 || c_chan !== CW'(2) || c_x_re !== 16'sd1000 || c_x_im !== -16'sd500 || credits !== CRW'(7)) begin
            bad++;
            $display("FAIL single_issue: v=%0b ch=%0d re=%0d im=%0d credits=%0d want 1/2/1000/-500/7",
                     c_valid, c_chan, c_x_re, c_x_im, credits);
        end
        n = 0;
        while (m_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (n !== LAT || m_chan !== CW'(2)) begin
            bad++;
            $display("FAIL single_latency: got %0d cycles ch=%0d want %0d cycles ch=2", n, m_chan, LAT);
        end
        credit_ret = 1'b1;
        tick();
        credit_ret = 1'b0;
        total++;
        if (credits !== CRW'(CREDITS)) begin
            bad++;
            $display("FAIL single_credit_back: got %0d want %0d", credits, CREDITS);
        end
    endtask

    task automatic test_round_robin();
        int prev;
        rand_data();
        bus.s_valid = '1;
        tick();
        credit_ret = 1'b1;
        prev = int'(c_chan);
        total++;
        if (c_valid !== 1'b1 || prev !== 3) begin
            bad++;
            $display("FAIL rr_first: v=%0b ch=%0d want v=1 ch=3", c_valid, prev);
        end
        for (int i = 0; i < 12; i++) begin
            rand_data();
            tick();
            total++;
            if (c_valid !== 1'b1 || int'(c_chan) !== (prev + 1) % NCH || credits !== CRW'(7)) begin
                bad++;
                $display("FAIL rr_step%0d: v=%0b ch=%0d credits=%0d want v=1 ch=%0d credits=7",
                         i, c_valid, c_chan, credits, (prev + 1) % NCH);
            end
            prev = int'(c_chan);
        end
        bus.s_valid = '0;
        tick();
        credit_ret = 1'b0;
        total++;
        if (credits !== CRW'(CREDITS) || err_credit !== 1'b0) begin
            bad++;
            $display("FAIL rr_end: credits=%0d err=%0b want %0d/0", credits, err_credit, CREDITS);
        end
    endtask

    task automatic test_credit_exhaust();
        int cnt;
        rand_data();
        bus.s_valid = '1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (c_valid === 1'b1) cnt++;
        end
        total++;
        if (cnt !== CREDITS || bus.s_ready !== '0 || credits !== CRW'(0)) begin
            bad++;
            $display("FAIL exhaust: grants=%0d ready=%b credits=%0d want %0d/0000/0", cnt, bus.s_ready, credits, CREDITS);
        end
        credit_ret = 1'b1;
        tick();
        credit_ret = 1'b0;
        total++;
        if (credits !== CRW'(1) || $countones(bus.s_ready) !== 1) begin
            bad++;
            $display("FAIL exhaust_refill: credits=%0d ready=%b want 1 and one-hot", credits, bus.s_ready);
        end
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (c_valid === 1'b1) cnt++;
        end
        total++;
        if (cnt !== 1 || credits !== CRW'(0)) begin
            bad++;
            $display("FAIL exhaust_one_more: grants=%0d credits=%0d want 1/0", cnt, credits);
        end
        bus.s_valid = '0;
        credit_ret = 1'b1;
        repeat (CREDITS) tick();
        credit_ret = 1'b0;
        total++;
        if (credits !== CRW'(CREDITS)) begin
            bad++;
            $display("FAIL exhaust_restore: got %0d want %0d", credits, CREDITS);
        end
    endtask

    task automatic test_credit_edge();
        rand_data();
        bus.s_valid = 4'b0001;
        repeat (3) tick();
        total++;
        if (credits !== CRW'(5)) begin
            bad++;
            $display("FAIL edge_at5: got %0d want 5", credits);
        end
        credit_ret = 1'b1;
        tick();
        bus.s_valid = '0;
        total++;
        if (credits !== CRW'(5) || c_valid !== 1'b1 || err_credit !== 1'b0) begin
            bad++;
            $display("FAIL edge_simul: credits=%0d c_valid=%0b err=%0b want 5/1/0", credits, c_valid, err_credit);
        end
        repeat (3) tick();
        total++;
        if (credits !== CRW'(CREDITS) || err_credit !== 1'b0) begin
            bad++;
            $display("FAIL edge_full: credits=%0d err=%0b want %0d/0", credits, err_credit, CREDITS);
        end
        tick();
        credit_ret = 1'b0;
        total++;
        if (credits !== CRW'(CREDITS) || err_credit !== 1'b1) begin
            bad++;
            $display("FAIL edge_over_return: credits=%0d err=%0b want %0d/1", credits, err_credit, CREDITS);
        end
    endtask

    task automatic test_enable_drain();
        int cnt;
        repeat (LAT + 2) tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL drain_idle_busy: got %0b want 0", busy);
        end
        enable = 1'b1;
        rand_data();
        bus.s_valid = '1;
        repeat (3) tick();
        enable = 1'b0;
        #1;
        total++;
        if (credits !== CRW'(5) || bus.s_ready !== '0) begin
            bad++;
            $display("FAIL drain_stop: credits=%0d ready=%b want 5/0000", credits, bus.s_ready);
        end
        cnt = 0;
        for (int i = 0; i < LAT + 5; i++) begin
            tick();
            if (m_valid === 1'b1) cnt++;
            total++;
            if (bus.s_ready !== '0) begin
                bad++;
                $display("FAIL drain_ready%0d: got %b want 0000", i, bus.s_ready);
            end
        end
        total++;
        if (cnt !== 3 || credits !== CRW'(5) || busy !== 1'b1) begin
            bad++;
            $display("FAIL drain_results: pulses=%0d credits=%0d busy=%0b want 3/5/1", cnt, credits, busy);
        end
        bus.s_valid = '0;
        credit_ret = 1'b1;
        repeat (2) tick();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL drain_busy_held: got %0b want 1", busy);
        end
        tick();
        credit_ret = 1'b0;
        total++;
        if (busy !== 1'b0 || credits !== CRW'(CREDITS)) begin
            bad++;
            $display("FAIL drain_busy_fall: busy=%0b credits=%0d want 0/%0d", busy, credits, CREDITS);
        end
    endtask

    task automatic test_reset_midstream();
        int cnt;
        enable = 1'b1;
        rand_data();
        bus.s_valid = '1;
        repeat (6) tick();
        bus.s_valid = '0;
        reset = 1'b0;
        #1;
        total++;
        if (c_valid !== 1'b0 || m_valid !== 1'b0 || credits !== CRW'(CREDITS) || busy !== 1'b0 ||
            err_credit !== 1'b0 || c_x_re !== 16'sd0 || c_chan !== '0) begin
            bad++;
            $display("FAIL midreset_now: c_valid=%0b m_valid=%0b credits=%0d busy=%0b err=%0b want 0/0/%0d/0/0",
                     c_valid, m_valid, credits, busy, err_credit, CREDITS);
        end
        repeat (2) tick();
        reset = 1'b1;
        cnt = 0;
        repeat (LAT + 4) begin
            tick();
            if (m_valid === 1'b1) cnt++;
        end
        total++;
        if (cnt !== 0) begin
            bad++;
            $display("FAIL midreset_ghost: got %0d results want 0", cnt);
        end
        rand_data();
        bus.s_valid = '1;
        tick();
        bus.s_valid = '0;
        total++;
        if (c_valid !== 1'b1 || c_chan !== CW'(0)) begin
            bad++;
            $display("FAIL midreset_ptr: v=%0b ch=%0d want 1/0", c_valid, c_chan);
        end
        repeat (LAT + 2) tick();
        credit_ret = 1'b1;
        tick();
        credit_ret = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_credit_exhaust();
        test_credit_edge();
        test_enable_drain();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/cordic_rr_scheduler.md
# cordic_rr_scheduler

Round-robin scheduler that shares the single pipelined CORDIC vectoring datapath (input glue, CORDIC, output glue) among NCH independent IQ channels. Accepts samples from per-channel valid/ready ports, issues at most one sample per cycle into the non-stallable CORDIC pipeline, and carries a channel tag alongside it so results leave with the correct channel ID. Downstream buffer space (per-channel delta-phase/wrap stage) is protected by a credit counter.

## Interface
- NCH, 4: number of requesting channels (2..16)
- LAT, 18: fixed cycle latency from c_valid to the matching result at the CORDIC/glue output
- CREDITS, 8: downstream result slots; max samples in flight and not yet retired
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  when 0, no new grants; in-flight samples drain normally
- s_valid  in  NCH  per-channel sample valid
- s_ready  out  NCH  per-channel accept; one-hot or zero
- s_x_re  in  NCH×16  signed, packed, channel i at [16i+15:16i]
- s_x_im  in  NCH×16  signed, packed, same layout
- c_x_re  out  16  signed, to CORDIC input glue x_re
- c_x_im  out  16  signed, to CORDIC input glue x_im
- c_valid  out  1  c_x_re/c_x_im hold an issued sample
- c_chan  out  CW  channel of the issued sample; CW = max(1, $clog2(NCH))
- m_valid  out  1  CORDIC result at this cycle belongs to a real sample
- m_chan  out  CW  channel tag of that result
- credit_ret  in  1  single-cycle pulse: downstream freed one slot
- credits  out  $clog2(CREDITS+1)  current available credits
- busy  out  1  any sample in flight (tag pipe non-empty or credits < CREDITS)
- err_credit  out  1  sticky: credit_ret received with credits == CREDITS

## Operation
- Grant condition: enable && credits != 0 && |s_valid.
- Arbiter: round-robin pointer ptr; winner = first i with s_valid[i], searching ptr, ptr+1, …, NCH-1, 0, …, ptr-1 (mod NCH).
- s_ready[winner] = 1 when grant condition holds, all other bits 0; combinational from s_valid, ptr, credits, enable.
- On handshake (s_valid[i] && s_ready[i]): register s_x_re[i], s_x_im[i] into c_x_re/c_x_im, c_chan = i, c_valid = 1; ptr ← (i+1) mod NCH.
- No handshake: c_valid = 0, c_x_re = c_x_im = 0, c_chan = 0; ptr unchanged.
- Tag pipe: LAT-stage shift register of {valid, chan}, loaded from {c_valid, c_chan}; last stage drives m_valid/m_chan. Shifts every cycle (CORDIC never stalls).
- Credits: −1 on handshake, +1 on credit_ret; both in same cycle → unchanged. credit_ret at credits == CREDITS → credits unchanged, err_credit ← 1 (cleared only by reset). Handshake never occurs at credits == 0.
- enable deassert mid-stream: grants stop the same cycle; tag pipe and credits continue.
- Reset (any time, including mid-stream): c_valid=0, c_x_re=c_x_im=0, c_chan=0, tag pipe all invalid (m_valid=0, m_chan=0), ptr=0, credits=CREDITS, err_credit=0, busy=0. Results emerging from the CORDIC after reset are tagged invalid.

## Timing
- Handshake in cycle T → c_valid high in T+1 → m_valid high in T+1+LAT with m_chan = channel.
- Throughput: one sample per cycle while credits allow; any channel held valid with others active waits at most NCH−1 grants.
- credits output reflects the registered counter; a credit returned in cycle T is usable for a grant in T+1.
- s_ready has no register stage; s_valid must not depend combinationally on s_ready.

## Structure
- Shared package cordic_pkg: DATA_W=16, ANGLE_W=18, CORDIC pipeline latency constant (default for LAT), chan tag typedef.
- One natural sub-module: rr_arbiter (NCH requests, ptr, one-hot grant, winner index); tag pipe, credit counter and issue registers stay in the top.

## Test plan
- Single channel: ch2 sends re=1000, im=−500 in cycle 10 → c_valid cycle 11 with c_x_re=1000, c_x_im=−500, c_chan=2; m_valid, m_chan=2 at cycle 11+LAT; credits 8→7.
- All 4 channels valid continuously, credit_ret every cycle → grants 0,1,2,3,0,1… one per cycle, no gaps, credits stay constant.
- No credit_ret, all valid → exactly 8 handshakes then s_ready=0, credits=0; one credit_ret pulse → exactly one more grant next cycle.
- Simultaneous handshake and credit_ret at credits=5 → credits stays 5; credit_ret with credits=8 → err_credit=1, credits=8.
- enable dropped with 3 samples in flight → no new s_ready, 3 m_valid pulses still appear at correct cycles, busy falls after last credit returned.
- reset asserted with pipe half full → all outputs zero immediately, no m_valid afterwards, credits=8, ptr restarts at channel 0.
